// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Byte address to word index shift (32-bit words)
  localparam int WORD_OFF = 2;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational grant selection between fetch and data requesters
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise the data port has fixed priority.
module arb_pick (
`ifdef MEM_ARB_RR_EN
  input  logic clk,
`endif
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  logic d_win;

`ifdef MEM_ARB_RR_EN
  // 1 = data port holds the most recent grant, so fetch wins the next conflict
  logic last_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else if (i_gnt || d_gnt) begin
      last_d_q <= d_gnt;
    end
  end

  always_comb begin
    d_win = d_req && (!i_req || !last_d_q);
  end
`else
  always_comb begin
    d_win = d_req;
  end
`endif

  always_comb begin
    d_gnt = !reset && d_win;
    i_gnt = !reset && i_req && !d_win;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one single-cycle-latency memory
// Optional macro MEM_ARB_RR_EN enables round-robin arbitration in arb_pick.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_gnt,
  output logic                         i_rvalid,
  output logic [DATA_W-1:0]            i_rdata,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         d_err,
  output logic                         m_en,
  output logic                         m_we,
  output logic [$clog2(MEM_DEPTH)-1:0] m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W-1:0]            m_rdata
);

  localparam int AW = $clog2(MEM_DEPTH);

  owner_e owner_q, owner_d;
  logic   zero_q, zero_d;
  logic   derr_q, derr_d;
  logic   i_bad, d_bad;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[WORD_OFF-1:0] != '0) || ((a >> WORD_OFF) >= ADDR_W'(MEM_DEPTH));
  endfunction

  arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk   (clk),
`endif
    .reset (reset),
    .i_req (i_req),
    .d_req (d_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  // Faulting accesses are still granted but kept off the memory; zero_d forces rdata to 0
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    owner_d = OWN_NONE;
    zero_d  = 1'b0;
    derr_d  = 1'b0;
    i_bad   = addr_bad(i_addr);
    d_bad   = addr_bad(d_addr);
    if (d_gnt) begin
      m_en    = !d_bad;
      m_we    = d_we && !d_bad;
      m_addr  = d_addr[WORD_OFF +: AW];
      m_wdata = d_wdata;
      owner_d = OWN_DATA;
      zero_d  = d_bad || d_we;
      derr_d  = d_bad;
    end else if (i_gnt) begin
      m_en    = !i_bad;
      m_addr  = i_addr[WORD_OFF +: AW];
      owner_d = OWN_FETCH;
      zero_d  = i_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      zero_q  <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      zero_q  <= zero_d;
      derr_q  <= derr_d;
    end
  end

  // Response outputs are gated by reset so a grant just before reset never surfaces
  always_comb begin
    i_rvalid = !reset && (owner_q == OWN_FETCH);
    d_rvalid = !reset && (owner_q == OWN_DATA);
    i_rdata  = (i_rvalid && !zero_q) ? m_rdata : '0;
    d_rdata  = (d_rvalid && !zero_q) ? m_rdata : '0;
    d_err    = d_rvalid && derr_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_en, m_we;
  logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [5:0]  m_addr;
  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;
  bit rr;

  typedef struct packed {
    logic        vld;
    logic        is_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      m_rdata <= mem[m_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                      input logic eig, input logic edg, input logic emen, input logic emwe,
                      input logic [5:0] emaddr, input logic [31:0] edata, input logic eerr);
    exp_t p, e;
    logic xi, xd;
    reset = rst; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    p  = exp_q.pop_front();
    xi = p.vld && !p.is_data && !rst;
    xd = p.vld && p.is_data && !rst;
    chk("i_gnt",    32'(i_gnt),    32'(eig));
    chk("d_gnt",    32'(d_gnt),    32'(edg));
    chk("m_en",     32'(m_en),     32'(emen));
    chk("m_we",     32'(m_we),     32'(emwe));
    chk("m_addr",   32'(m_addr),   32'(emaddr));
    chk("m_wdata",  m_wdata,       edg ? dwd : 32'h0);
    chk("i_rvalid", 32'(i_rvalid), 32'(xi));
    chk("d_rvalid", 32'(d_rvalid), 32'(xd));
    chk("i_rdata",  i_rdata,       xi ? p.data : 32'h0);
    chk("d_rdata",  d_rdata,       xd ? p.data : 32'h0);
    chk("d_err",    32'(d_err),    32'(xd && p.err));
    e.vld = eig || edg; e.is_data = edg; e.data = edata; e.err = eerr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[2] = 32'hDEADBEEF;
    m_rdata = 32'h0;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    exp_q.push_back('0);
    @(posedge clk);
    #1;

    // reset with idle requesters: all outputs zero
    tick(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 6'd0, 0, 0);
    tick(1, 1, 8, 1, 1, 8, 5,   0, 0, 0, 0, 6'd0, 0, 0);

    // fetch-only read of mem[2]
    tick(0, 1, 32'h8, 0, 0, 0, 0,   1, 0, 1, 0, 6'd2, 32'hDEADBEEF, 0);
    tick(0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 6'd0, 0, 0);

    // conflict for 4 back-to-back cycles
    for (int k = 0; k < 4; k++) begin
      logic dw;
      dw = rr ? (k % 2 == 0) : 1'b1;
      tick(0, 1, 32'h8, 1, 0, 32'h8, 0,   !dw, dw, 1, 0, 6'd2, 32'hDEADBEEF, 0);
    end

    // store then load back-to-back
    tick(0, 0, 0, 1, 1, 32'h10, 32'h12345678,   0, 1, 1, 1, 6'd4, 32'h0, 0);
    tick(0, 0, 0, 1, 0, 32'h10, 0,              0, 1, 1, 0, 6'd4, 32'h12345678, 0);

    // data errors: misaligned then out of range
    tick(0, 0, 0, 1, 0, 32'h102, 0,   0, 1, 0, 0, 6'd0, 32'h0, 1);
    tick(0, 0, 0, 1, 0, 32'h100, 0,   0, 1, 0, 0, 6'd0, 32'h0, 1);

    // fetch error: rvalid with zero data, no d_err
    tick(0, 1, 32'h6, 0, 0, 0, 0,     1, 0, 0, 0, 6'd1, 32'h0, 0);

    // reset right after a grant, with a request held during reset
    tick(0, 1, 32'h8, 0, 0, 0, 0,     1, 0, 1, 0, 6'd2, 32'hDEADBEEF, 0);
    tick(1, 1, 32'h8, 0, 0, 0, 0,     0, 0, 0, 0, 6'd0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 6'd0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 6'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
